// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access controller: sizes, funct3, fault codes, FSM states.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_BOUNDS   = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Number of bytes touched by an access of the given size code.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_req_decode.sv
// Combinational request decode: funct3 -> memory size/sign-extend, plus the acceptance fault code.
module mem_req_decode
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 512,
    parameter int ADDR_W    = 32
) (
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic              store,
    output logic [1:0]        size,
    output logic              signext,
    output logic [1:0]        fault
);

    localparam int AW1 = ADDR_W + 1;

    logic           legal;
    logic           misaligned;
    logic           out_of_bounds;
    logic [AW1-1:0] last_byte;

    // Decode and fault classification; the extra address bit keeps wrap-around from looking in range.
    always_comb begin
        size    = funct3[1:0];
        signext = ~store & ~funct3[2];
        if (store) begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        misaligned    = ((size == SIZE_HALF) && addr[0]) ||
                        ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
        last_byte     = {1'b0, addr} + AW1'(size_bytes(size)) - AW1'(1);
        out_of_bounds = (last_byte >= AW1'(MEM_BYTES));
        if (!legal) begin
            fault = FAULT_ILLEGAL;
        end else if (misaligned) begin
            fault = FAULT_MISALIGN;
        end else if (out_of_bounds) begin
            fault = FAULT_BOUNDS;
        end else begin
            fault = FAULT_NONE;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: accepts one load/store, drives the data memory for one cycle, returns a response.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | req_ready high; waiting for a request (flush blocks accept)
// ST_ACCESS | dm_enable high for exactly this cycle; memory controls stable
// ST_RESP   | rsp_valid high; response held until rsp_ready or flush
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 512,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              dm_enable,
    output logic              dm_rw,
    output logic              dm_signext,
    output logic [1:0]        dm_size,
    output logic [31:0]       dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [4:0]        rsp_rd,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_fault,
    output logic [31:0]       rsp_fault_addr,
    input  logic              flush
);

    state_e      state_q, state_d;
    logic        dm_enable_q, dm_enable_d;
    logic        dm_rw_q, dm_rw_d;
    logic        dm_signext_q, dm_signext_d;
    logic [1:0]  dm_size_q, dm_size_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_we_q, rsp_we_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_fault_q, rsp_fault_d;
    logic [31:0] rsp_fault_addr_q, rsp_fault_addr_d;

    logic [1:0]  dec_size;
    logic        dec_signext;
    logic [1:0]  dec_fault;
    logic        accept;
    logic [31:0] addr_ext;

    mem_req_decode #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_decode (
        .funct3  (req_funct3),
        .addr    (req_addr),
        .store   (req_store),
        .size    (dec_size),
        .signext (dec_signext),
        .fault   (dec_fault)
    );

    assign addr_ext = 32'(req_addr);
    assign accept   = (state_q == ST_IDLE) && req_valid && !flush;

    // Next-state and next-output logic; memory controls keep their last value whenever not accessing.
    always_comb begin
        state_d          = state_q;
        dm_enable_d      = dm_enable_q;
        dm_rw_d          = dm_rw_q;
        dm_signext_d     = dm_signext_q;
        dm_size_d        = dm_size_q;
        dm_addr_d        = dm_addr_q;
        dm_wdata_d       = dm_wdata_q;
        rsp_valid_d      = rsp_valid_q;
        rsp_we_d         = rsp_we_q;
        rsp_rd_d         = rsp_rd_q;
        rsp_data_d       = rsp_data_q;
        rsp_fault_d      = rsp_fault_q;
        rsp_fault_addr_d = rsp_fault_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rsp_rd_d = req_rd;
                    if (dec_fault == FAULT_NONE) begin
                        dm_enable_d      = 1'b1;
                        dm_rw_d          = req_store;
                        dm_signext_d     = dec_signext;
                        dm_size_d        = dec_size;
                        dm_addr_d        = addr_ext;
                        dm_wdata_d       = req_wdata;
                        rsp_fault_d      = FAULT_NONE;
                        rsp_fault_addr_d = 32'd0;
                        state_d          = ST_ACCESS;
                    end else begin
                        rsp_valid_d      = 1'b1;
                        rsp_we_d         = 1'b0;
                        rsp_data_d       = 32'd0;
                        rsp_fault_d      = dec_fault;
                        rsp_fault_addr_d = addr_ext;
                        state_d          = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // A flushed store has already written during this cycle; only its response is dropped.
                dm_enable_d = 1'b0;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = ~dm_rw_q;
                    rsp_data_d  = dm_rw_q ? 32'd0 : dm_rdata;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush || rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_we_d    = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            dm_enable_q      <= 1'b0;
            dm_rw_q          <= 1'b0;
            dm_signext_q     <= 1'b0;
            dm_size_q        <= SIZE_BYTE;
            dm_addr_q        <= 32'd0;
            dm_wdata_q       <= 32'd0;
            rsp_valid_q      <= 1'b0;
            rsp_we_q         <= 1'b0;
            rsp_rd_q         <= 5'd0;
            rsp_data_q       <= 32'd0;
            rsp_fault_q      <= FAULT_NONE;
            rsp_fault_addr_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            dm_enable_q      <= dm_enable_d;
            dm_rw_q          <= dm_rw_d;
            dm_signext_q     <= dm_signext_d;
            dm_size_q        <= dm_size_d;
            dm_addr_q        <= dm_addr_d;
            dm_wdata_q       <= dm_wdata_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_we_q         <= rsp_we_d;
            rsp_rd_q         <= rsp_rd_d;
            rsp_data_q       <= rsp_data_d;
            rsp_fault_q      <= rsp_fault_d;
            rsp_fault_addr_q <= rsp_fault_addr_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign dm_enable      = dm_enable_q;
    assign dm_rw          = dm_rw_q;
    assign dm_signext     = dm_signext_q;
    assign dm_size        = dm_size_q;
    assign dm_addr        = dm_addr_q;
    assign dm_wdata       = dm_wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_we         = rsp_we_q;
    assign rsp_rd         = rsp_rd_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_fault      = rsp_fault_q;
    assign rsp_fault_addr = rsp_fault_addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array data memory on the dm_* side, reference model of RISC-V load/store.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        dm_enable;
    logic        dm_rw;
    logic        dm_signext;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_fault;
    logic [31:0] rsp_fault_addr;
    logic        flush;

    int tests = 0;
    int fails = 0;

    mem_access_ctrl #(.MEM_BYTES(512), .ADDR_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .dm_enable      (dm_enable),
        .dm_rw          (dm_rw),
        .dm_signext     (dm_signext),
        .dm_size        (dm_size),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_rdata       (dm_rdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_we         (rsp_we),
        .rsp_rd         (rsp_rd),
        .rsp_data       (rsp_data),
        .rsp_fault      (rsp_fault),
        .rsp_fault_addr (rsp_fault_addr),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT: combinational read, write on the rising edge.
    logic [7:0]  mem_env [0:511] = '{default: 8'h00};
    logic [8:0]  ea;
    logic [31:0] env_raw;
    int          env_nb;
    assign ea      = dm_addr[8:0];
    assign env_raw = {mem_env[ea + 9'd3], mem_env[ea + 9'd2], mem_env[ea + 9'd1], mem_env[ea]};
    assign env_nb  = (dm_size == 2'b00) ? 1 : (dm_size == 2'b01) ? 2 : 4;

    always_comb begin
        case (dm_size)
            2'b00:   dm_rdata = dm_signext ? {{24{env_raw[7]}}, env_raw[7:0]} : {24'h0, env_raw[7:0]};
            2'b01:   dm_rdata = dm_signext ? {{16{env_raw[15]}}, env_raw[15:0]} : {16'h0, env_raw[15:0]};
            default: dm_rdata = env_raw;
        endcase
    end

    always @(posedge clk) begin
        if (dm_enable && dm_rw) begin
            for (int i = 0; i < 4; i++) begin
                if (i < env_nb) mem_env[9'(ea + 9'(i))] <= dm_wdata[8*i +: 8];
            end
        end
    end

    // Reference architectural memory, updated only by the model.
    logic [7:0] ref_mem [0:511] = '{default: 8'h00};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of one request: fault code, load value, byte count, sign-extend flag.
    function automatic void ref_model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wd, output logic [1:0] flt,
                                      output logic [31:0] data, output int nb, output logic sx);
        logic   legal;
        logic   sgn;
        longint v;
        legal = 1'b1; nb = 1; sgn = 1'b0; sx = 1'b0; data = 32'd0;
        if (st) begin
            case (f3)
                3'd0: nb = 1;
                3'd1: nb = 2;
                3'd2: nb = 4;
                default: legal = 1'b0;
            endcase
        end else begin
            case (f3)
                3'd0: begin nb = 1; sgn = 1'b1; sx = 1'b1; end
                3'd1: begin nb = 2; sgn = 1'b1; sx = 1'b1; end
                3'd2: begin nb = 4; sx = 1'b1; end
                3'd4: nb = 1;
                3'd5: nb = 2;
                default: legal = 1'b0;
            endcase
        end
        if (!legal) flt = 2'd3;
        else if ((longint'(addr) % nb) != 0) flt = 2'd1;
        else if (longint'(addr) + nb > 512) flt = 2'd2;
        else begin
            flt = 2'd0;
            if (st) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(addr[8:0]) + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v + (longint'(ref_mem[int'(addr[8:0]) + i]) << (8 * i));
                if (sgn && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
                data = v[31:0];
            end
        end
    endfunction

    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, input int bp);
        logic [1:0]  ef;
        logic [31:0] ed;
        int          nb;
        logic        sx;
        int          lat;
        int          en_cnt;
        ref_model(st, f3, addr, wd, ef, ed, nb, sx);
        send(st, f3, addr, wd, rd);
        lat = 0; en_cnt = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (dm_enable) begin
                en_cnt++;
                check("dm_rw", 32'(dm_rw), 32'(st));
                check("dm_size", 32'(dm_size), (nb == 1) ? 32'd0 : (nb == 2) ? 32'd1 : 32'd2);
                check("dm_signext", 32'(dm_signext), 32'(sx));
                check("dm_addr", dm_addr, addr);
                if (st) check("dm_wdata", dm_wdata, wd);
            end
            if (rsp_valid) break;
        end
        check("rsp_latency", 32'(lat), (ef == 2'd0) ? 32'd2 : 32'd1);
        check("dm_enable_cycles", 32'(en_cnt), (ef == 2'd0) ? 32'd1 : 32'd0);
        check("rsp_fault", 32'(rsp_fault), 32'(ef));
        check("rsp_we", 32'(rsp_we), 32'(ef == 2'd0 && !st));
        check("rsp_rd", 32'(rsp_rd), 32'(rd));
        if (ef == 2'd0) check("rsp_data", rsp_data, st ? 32'd0 : ed);
        else check("rsp_fault_addr", rsp_fault_addr, addr);
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_fault", 32'(rsp_fault), 32'(ef));
            if (ef == 2'd0) check("bp_rsp_data", rsp_data, st ? 32'd0 : ed);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("ready_after_hs", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  mf;
        logic [31:0] md;
        int          mnb;
        logic        msx;
        logic        seen;
        logic        rst;
        logic [2:0]  rf3;
        logic [31:0] ra;

        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
        req_wdata = 32'd0; req_rd = 5'd0; rsp_ready = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_dm_enable", 32'(dm_enable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        reset = 1'b0;

        // Word store/load round trip
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0, 0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 5'd5, 0);
        // Byte store, signed and unsigned byte loads
        do_req(1'b1, 3'd0, 32'h21, 32'h000000F0, 5'd0, 0);
        do_req(1'b0, 3'd0, 32'h21, 32'h0, 5'd6, 0);
        do_req(1'b0, 3'd4, 32'h21, 32'h0, 5'd7, 0);
        // Halfword paths
        do_req(1'b1, 3'd1, 32'h30, 32'hCAFE8001, 5'd0, 0);
        do_req(1'b0, 3'd1, 32'h30, 32'h0, 5'd8, 0);
        do_req(1'b0, 3'd5, 32'h30, 32'h0, 5'd9, 0);
        // Faults: misaligned, bounds edges, wrap, illegal
        do_req(1'b0, 3'd1, 32'h13, 32'h0, 5'd3, 0);
        do_req(1'b0, 3'd2, 32'h1FE, 32'h0, 5'd3, 0);
        do_req(1'b0, 3'd2, 32'h200, 32'h0, 5'd3, 0);
        do_req(1'b1, 3'd2, 32'h1FC, 32'h11223344, 5'd0, 0);
        do_req(1'b0, 3'd2, 32'h1FC, 32'h0, 5'd4, 0);
        do_req(1'b0, 3'd1, 32'h1FE, 32'h0, 5'd4, 0);
        do_req(1'b0, 3'd0, 32'h1FF, 32'h0, 5'd4, 0);
        do_req(1'b1, 3'd2, 32'hFFFFFFFC, 32'h1, 5'd0, 0);
        do_req(1'b0, 3'd3, 32'h10, 32'h0, 5'd2, 0);
        do_req(1'b1, 3'd4, 32'h10, 32'h55, 5'd0, 0);
        // Backpressure on a load response
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 5'd12, 5);

        // Flush while a store is in ACCESS: write lands, no response
        ref_model(1'b1, 3'd2, 32'h40, 32'h12345678, mf, md, mnb, msx);
        send(1'b1, 3'd2, 32'h40, 32'h12345678, 5'd0);
        @(negedge clk);
        check("flush_st_access_en", 32'(dm_enable), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        check("flush_st_no_rsp", 32'(seen), 32'd0);
        check("flush_st_idle", 32'(req_ready), 32'd1);
        do_req(1'b0, 3'd2, 32'h40, 32'h0, 5'd1, 0);

        // Flush while a load is in ACCESS: discarded
        send(1'b0, 3'd2, 32'h10, 32'h0, 5'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        check("flush_ld_no_rsp", 32'(seen), 32'd0);

        // Flush in IDLE blocks acceptance; the store must never reach memory
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h80; req_wdata = 32'hA5A5A5A5;
        flush = 1'b1;
        @(posedge clk);
        #1 begin req_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flush_idle_no_en", 32'(dm_enable), 32'd0);
        check("flush_idle_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 3'd2, 32'h80, 32'h0, 5'd2, 0);

        // Flush together with rsp_ready in RESP: response dropped, back to IDLE
        send(1'b0, 3'd2, 32'h10, 32'h0, 5'd9);
        @(negedge clk);
        @(negedge clk);
        check("resp_flush_pre", 32'(rsp_valid), 32'd1);
        flush = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1 begin flush = 1'b0; rsp_ready = 1'b0; end
        @(negedge clk);
        check("resp_flush_valid", 32'(rsp_valid), 32'd0);
        check("resp_flush_ready", 32'(req_ready), 32'd1);

        // Randomized requests against the reference model
        for (int k = 0; k < 60; k++) begin
            rst = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       ra = 32'($urandom_range(0, 511));
                1:       ra = 32'($urandom_range(0, 127)) * 32'd4;
                2:       ra = 32'($urandom_range(500, 530));
                default: ra = $urandom;
            endcase
            do_req(rst, rf3, ra, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        // Reset while a store is in ACCESS
        ref_model(1'b1, 3'd2, 32'h1F0, 32'h0BADF00D, mf, md, mnb, msx);
        send(1'b1, 3'd2, 32'h1F0, 32'h0BADF00D, 5'd17);
        @(negedge clk);
        check("rst_acc_en_pre", 32'(dm_enable), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_acc_dm_enable", 32'(dm_enable), 32'd0);
        check("rst_acc_dm_rw", 32'(dm_rw), 32'd0);
        check("rst_acc_dm_addr", dm_addr, 32'd0);
        check("rst_acc_dm_wdata", dm_wdata, 32'd0);
        check("rst_acc_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_acc_rsp_rd", 32'(rsp_rd), 32'd0);
        check("rst_acc_req_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 3'd2, 32'h1F0, 32'h0, 5'd3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
